// File: rtl/reorder_pkg.sv
// Shared reorder-tag definitions: status codes, table defaults and
// the per-tag verdict arbitration helper used by the status table.
package reorder_pkg;

  localparam int DEF_TAG_WIDTH  = 6;
  localparam int DEF_TABLE_SIZE = 50;

  // Padded widths the arbitration helper works on.
  localparam int MAX_CORES = 8;
  localparam int MAX_TAG_W = 8;

  localparam logic [1:0] FREE    = 2'b00;
  localparam logic [1:0] PENDING = 2'b10;
  localparam logic [1:0] REJECT  = 2'b01;
  localparam logic [1:0] ACCEPT  = 2'b11;

  // Core k loses its tag when any lower-index valid core carries the
  // same tag, so the lowest index always wins.
  function automatic logic beaten(
    input logic [MAX_CORES-1:0]           valid,
    input logic [MAX_CORES*MAX_TAG_W-1:0] tags,
    input int                             k
  );
    logic b;
    b = 1'b0;
    for (int j = 0; j < MAX_CORES; j++) begin
      if (j < k && valid[j] &&
          tags[j*MAX_TAG_W +: MAX_TAG_W] ==
          tags[k*MAX_TAG_W +: MAX_TAG_W])
        b = 1'b1;
    end
    return b;
  endfunction

endpackage

// File: rtl/verdict_popcount.sv
// Counts the verdicts that take effect this cycle, split by outcome.
// Ports: i_eff/i_accept per core in, o_acc/o_rej counts out.
module verdict_popcount #(
  parameter int N_CORES = 4,
  parameter int PW      = 3
) (
  input  logic [N_CORES-1:0] i_eff,
  input  logic [N_CORES-1:0] i_accept,
  output logic [PW-1:0]      o_acc,
  output logic [PW-1:0]      o_rej
);

  always_comb begin
    o_acc = '0;
    o_rej = '0;
    for (int k = 0; k < N_CORES; k++) begin
      if (i_eff[k]) begin
        if (i_accept[k]) o_acc = o_acc + PW'(1);
        else             o_rej = o_rej + PW'(1);
      end
    end
  end

endmodule

// File: rtl/reorder_status_table.sv
// Per-packet verdict table: alloc by forwarder, verdicts by filter
// cores, status read and release by the circular buffer.
// Ports: alloc_*, vrd_*, rd_tag/packet_status, release_en (the
// buffer's release pulse; "release" is a reserved word), counters,
// err_sticky.
module reorder_status_table
  import reorder_pkg::*;
#(
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int TABLE_SIZE = DEF_TABLE_SIZE,
  parameter int N_CORES    = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid,
  input  logic [TAG_WIDTH-1:0]         alloc_tag,
  output logic                         alloc_ready,
  input  logic [N_CORES-1:0]           vrd_valid,
  input  logic [N_CORES*TAG_WIDTH-1:0] vrd_tag,
  input  logic [N_CORES-1:0]           vrd_accept,
  input  logic [TAG_WIDTH-1:0]         rd_tag,
  output logic [1:0]                   packet_status,
  input  logic                         release_en,
  output logic [TAG_WIDTH:0]           pending_count,
  output logic [CNT_WIDTH-1:0]         accept_cnt,
  output logic [CNT_WIDTH-1:0]         reject_cnt,
  output logic                         err_sticky
);

  localparam logic [TAG_WIDTH:0] LP_SIZE =
    (TAG_WIDTH+1)'(TABLE_SIZE);
  localparam int PW = $clog2(N_CORES + 1);

  logic [1:0]           r_state [TABLE_SIZE];
  logic [1:0]           w_next  [TABLE_SIZE];
  logic [TAG_WIDTH:0]   r_pend;
  logic [CNT_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_rej;
  logic                 r_err;

  logic                 w_alloc_in;
  logic [1:0]           w_alloc_st;
  logic                 w_alloc_hs;
  logic                 w_rd_in;
  logic [1:0]           w_rd_st;
  logic                 w_rel_eff;
  logic                 w_rel_err;

  logic [MAX_CORES-1:0]           w_vpad;
  logic [MAX_CORES*MAX_TAG_W-1:0] w_tpad;
  logic [TAG_WIDTH-1:0]           w_vtag [N_CORES];
  logic [1:0]                     w_vst  [N_CORES];
  logic [N_CORES-1:0]             w_vin;
  logic [N_CORES-1:0]             w_eff;
  logic                           w_verr;
  logic [PW-1:0]                  w_nacc;
  logic [PW-1:0]                  w_nrej;

  // Lookups; out-of-range tags read as FREE.
  always_comb begin
    w_alloc_in = {1'b0, alloc_tag} < LP_SIZE;
    w_alloc_st = w_alloc_in ? r_state[alloc_tag] : FREE;
    w_rd_in    = {1'b0, rd_tag} < LP_SIZE;
    w_rd_st    = w_rd_in ? r_state[rd_tag] : FREE;
  end

  assign alloc_ready = w_alloc_in && (w_alloc_st == FREE);
  assign w_alloc_hs  = alloc_valid && alloc_ready;

  assign w_rel_eff = release_en &&
    (w_rd_st == ACCEPT || w_rd_st == REJECT);
  assign w_rel_err = release_en && !w_rel_eff;

  // Verdicts only act on entries that are PENDING before the edge.
  always_comb begin
    w_vpad = '0;
    w_tpad = '0;
    w_eff  = '0;
    w_verr = 1'b0;
    for (int k = 0; k < N_CORES; k++) begin
      w_vtag[k] = vrd_tag[k*TAG_WIDTH +: TAG_WIDTH];
      w_vin[k]  = {1'b0, w_vtag[k]} < LP_SIZE;
      w_vst[k]  = w_vin[k] ? r_state[w_vtag[k]] : FREE;
      w_vpad[k] = vrd_valid[k];
      w_tpad[k*MAX_TAG_W +: MAX_TAG_W] = MAX_TAG_W'(w_vtag[k]);
    end
    for (int k = 0; k < N_CORES; k++) begin
      if (vrd_valid[k]) begin
        if (beaten(w_vpad, w_tpad, k))
          w_verr = 1'b1;
        else if (w_vin[k] && w_vst[k] == PENDING)
          w_eff[k] = 1'b1;
        else
          w_verr = 1'b1;
      end
    end
  end

  verdict_popcount #(
    .N_CORES (N_CORES),
    .PW      (PW)
  ) u_pop (
    .i_eff    (w_eff),
    .i_accept (vrd_accept),
    .o_acc    (w_nacc),
    .o_rej    (w_nrej)
  );

  // Next state per entry. Alloc needs FREE, verdict PENDING and
  // release a decided entry, so at most one event hits an entry.
  always_comb begin
    for (int e = 0; e < TABLE_SIZE; e++) begin
      w_next[e] = r_state[e];
      if (w_alloc_hs && alloc_tag == TAG_WIDTH'(e))
        w_next[e] = PENDING;
      for (int k = 0; k < N_CORES; k++) begin
        if (w_eff[k] && w_vtag[k] == TAG_WIDTH'(e))
          w_next[e] = vrd_accept[k] ? ACCEPT : REJECT;
      end
      if (w_rel_eff && rd_tag == TAG_WIDTH'(e))
        w_next[e] = FREE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < TABLE_SIZE; e++)
        r_state[e] <= FREE;
      r_pend <= '0;
      r_acc  <= '0;
      r_rej  <= '0;
      r_err  <= 1'b0;
    end else begin
      for (int e = 0; e < TABLE_SIZE; e++)
        r_state[e] <= w_next[e];
      r_pend <= r_pend
        + (TAG_WIDTH+1)'(w_alloc_hs)
        - (TAG_WIDTH+1)'(w_rel_eff);
      r_acc <= r_acc + CNT_WIDTH'(w_nacc);
      r_rej <= r_rej + CNT_WIDTH'(w_nrej);
      if (w_verr || w_rel_err)
        r_err <= 1'b1;
    end
  end

  assign packet_status = w_rd_st;
  assign pending_count = r_pend;
  assign accept_cnt    = r_acc;
  assign reject_cnt    = r_rej;
  assign err_sticky    = r_err;

endmodule

// File: tb/tb_reorder_status_table.sv
// Bench for reorder_status_table: table-level model checked every
// cycle plus directed scenarios with literal expectations.
module tb_reorder_status_table;

  localparam int TS = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [5:0]  alloc_tag;
  logic        alloc_ready;
  logic [3:0]  vrd_valid;
  logic [23:0] vrd_tag;
  logic [3:0]  vrd_accept;
  logic [5:0]  rd_tag;
  logic [1:0]  packet_status;
  logic        release_en;
  logic [6:0]  pending_count;
  logic [31:0] accept_cnt;
  logic [31:0] reject_cnt;
  logic        err_sticky;

  reorder_status_table dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid   (alloc_valid),
    .alloc_tag     (alloc_tag),
    .alloc_ready   (alloc_ready),
    .vrd_valid     (vrd_valid),
    .vrd_tag       (vrd_tag),
    .vrd_accept    (vrd_accept),
    .rd_tag        (rd_tag),
    .packet_status (packet_status),
    .release_en    (release_en),
    .pending_count (pending_count),
    .accept_cnt    (accept_cnt),
    .reject_cnt    (reject_cnt),
    .err_sticky    (err_sticky)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: status per tag as plain codes, counters as integers.
  localparam logic [1:0] M_FREE = 2'b00;
  localparam logic [1:0] M_PEND = 2'b10;
  localparam logic [1:0] M_REJ  = 2'b01;
  localparam logic [1:0] M_ACC  = 2'b11;

  logic [1:0]  m_st  [TS];
  logic [1:0]  m_pre [TS];
  bit          m_claim [64];
  int          m_pend;
  logic [31:0] m_acc;
  logic [31:0] m_rej;
  bit          m_err;
  bit          m_live = 1'b0;
  int          ma, mt, mr;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        foreach (m_st[i]) m_st[i] = M_FREE;
        m_pend = 0;
        m_acc  = 0;
        m_rej  = 0;
        m_err  = 1'b0;
        m_live = 1'b1;
      end else if (m_live) begin
        m_pre = m_st;
        foreach (m_claim[i]) m_claim[i] = 1'b0;
        ma = int'(alloc_tag);
        if (alloc_valid && ma < TS && m_pre[ma] == M_FREE) begin
          m_st[ma] = M_PEND;
          m_pend++;
        end
        for (int k = 0; k < 4; k++) begin
          if (vrd_valid[k]) begin
            mt = int'(vrd_tag[k*6 +: 6]);
            if (m_claim[mt]) m_err = 1'b1;
            else begin
              m_claim[mt] = 1'b1;
              if (mt >= TS || m_pre[mt] != M_PEND) m_err = 1'b1;
              else if (vrd_accept[k]) begin
                m_st[mt] = M_ACC;
                m_acc = m_acc + 1;
              end else begin
                m_st[mt] = M_REJ;
                m_rej = m_rej + 1;
              end
            end
          end
        end
        if (release_en) begin
          mr = int'(rd_tag);
          if (mr < TS &&
              (m_pre[mr] == M_ACC || m_pre[mr] == M_REJ)) begin
            m_st[mr] = M_FREE;
            m_pend--;
          end else m_err = 1'b1;
        end
      end
    end
  end

  logic [1:0] e_st;
  logic       e_rdy;

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        e_st = M_FREE;
        if (int'(rd_tag) < TS) e_st = m_st[int'(rd_tag)];
        e_rdy = 1'b0;
        if (int'(alloc_tag) < TS)
          e_rdy = (m_st[int'(alloc_tag)] == M_FREE);
        chk("cmp_status", packet_status, e_st);
        chk("cmp_ready", alloc_ready, e_rdy);
        chk("cmp_pend", pending_count, m_pend);
        chk("cmp_acc", accept_cnt, m_acc);
        chk("cmp_rej", reject_cnt, m_rej);
        chk("cmp_err", err_sticky, m_err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    vrd_valid   = '0;
    release_en  = 1'b0;
    #1;
  endtask

  task automatic peek(int t);
    rd_tag = t[5:0];
    #1;
  endtask

  task automatic vrd(int k, int t, bit acc);
    vrd_valid[k]         = 1'b1;
    vrd_tag[k*6 +: 6]    = t[5:0];
    vrd_accept[k]        = acc;
  endtask

  task automatic do_alloc(int t);
    alloc_valid = 1'b1;
    alloc_tag   = t[5:0];
    step();
  endtask

  task automatic do_rel(int t);
    release_en = 1'b1;
    rd_tag     = t[5:0];
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0;
    alloc_tag = '0;
    vrd_valid = '0;
    vrd_tag = '0;
    vrd_accept = '0;
    rd_tag = '0;
    release_en = 1'b0;
    step();
    step();
    rst = 1'b0;

    rd_tag = 6'd5;
    alloc_tag = 6'd5;
    #1;
    chk("rst_pend", pending_count, 0);
    chk("rst_acc", accept_cnt, 0);
    chk("rst_rej", reject_cnt, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_status", packet_status, 2'b00);
    chk("rst_ready", alloc_ready, 1);

    // Basic life cycle on tag 5.
    do_alloc(5);
    peek(5);
    chk("t1_pending", packet_status, 2'b10);
    chk("t1_pend1", pending_count, 1);
    vrd(2, 5, 1'b1);
    step();
    chk("t1_accept", packet_status, 2'b11);
    chk("t1_acc", accept_cnt, 1);
    chk("t1_pend2", pending_count, 1);
    do_rel(5);
    chk("t1_free", packet_status, 2'b00);
    chk("t1_pend3", pending_count, 0);

    // Two cores, two tags.
    do_alloc(7);
    do_alloc(9);
    vrd(0, 7, 1'b0);
    vrd(3, 9, 1'b1);
    step();
    peek(7);
    chk("t2_tag7", packet_status, 2'b01);
    peek(9);
    chk("t2_tag9", packet_status, 2'b11);
    chk("t2_acc", accept_cnt, 2);
    chk("t2_rej", reject_cnt, 1);
    chk("t2_err", err_sticky, 0);
    do_rel(7);
    do_rel(9);

    // Duplicate tag: core 1 wins.
    do_alloc(4);
    vrd(1, 4, 1'b1);
    vrd(2, 4, 1'b0);
    step();
    peek(4);
    chk("t3_status", packet_status, 2'b11);
    chk("t3_acc", accept_cnt, 3);
    chk("t3_rej", reject_cnt, 1);
    chk("t3_err", err_sticky, 1);
    do_rel(4);

    // Fill the table, then wrap tag 0.
    do_reset();
    for (int t = 0; t < TS; t++) do_alloc(t);
    chk("fill_pend", pending_count, 50);
    alloc_tag = 6'd0;
    #1;
    chk("fill_ready0", alloc_ready, 0);
    vrd(0, 0, 1'b1);
    step();
    do_rel(0);
    alloc_tag = 6'd0;
    #1;
    chk("wrap_ready", alloc_ready, 1);
    chk("wrap_free", packet_status, 2'b00);
    do_alloc(0);
    peek(0);
    chk("wrap_pending", packet_status, 2'b10);
    chk("wrap_pend", pending_count, 50);

    // Release and alloc on tag 12 in the same cycle.
    vrd(1, 12, 1'b1);
    step();
    peek(12);
    chk("c12_accept", packet_status, 2'b11);
    alloc_valid = 1'b1;
    alloc_tag   = 6'd12;
    release_en  = 1'b1;
    #1;
    chk("c12_ready_lo", alloc_ready, 0);
    step();
    chk("c12_free", packet_status, 2'b00);
    chk("c12_pend49", pending_count, 49);
    alloc_valid = 1'b1;
    alloc_tag   = 6'd12;
    #1;
    chk("c12_ready_hi", alloc_ready, 1);
    step();
    chk("c12_pending", packet_status, 2'b10);
    chk("c12_pend50", pending_count, 50);
    chk("c12_acc", accept_cnt, 2);

    // Verdict to a FREE tag.
    do_reset();
    vrd(0, 20, 1'b1);
    step();
    chk("e20_err", err_sticky, 1);
    peek(20);
    chk("e20_status", packet_status, 2'b00);
    chk("e20_acc", accept_cnt, 0);

    // Verdict with an out-of-range tag.
    do_reset();
    vrd(3, 55, 1'b0);
    step();
    chk("e55_err", err_sticky, 1);
    peek(55);
    chk("e55_status", packet_status, 2'b00);
    chk("e55_rej", reject_cnt, 0);

    // Release and verdict on decided tag 2: release wins.
    do_reset();
    do_alloc(2);
    vrd(0, 2, 1'b1);
    step();
    chk("rv_err0", err_sticky, 0);
    release_en = 1'b1;
    rd_tag = 6'd2;
    vrd(1, 2, 1'b0);
    step();
    chk("rv_status", packet_status, 2'b00);
    chk("rv_err1", err_sticky, 1);
    chk("rv_acc", accept_cnt, 1);
    chk("rv_rej", reject_cnt, 0);
    chk("rv_pend", pending_count, 0);

    // Mid-operation reset with three entries pending.
    do_alloc(1);
    do_alloc(2);
    do_alloc(3);
    chk("mr_pend3", pending_count, 3);
    rst = 1'b1;
    step();
    chk("mr_pend0", pending_count, 0);
    chk("mr_acc", accept_cnt, 0);
    chk("mr_rej", reject_cnt, 0);
    chk("mr_err", err_sticky, 0);
    peek(2);
    chk("mr_status", packet_status, 2'b00);
    alloc_tag = 6'd3;
    #1;
    chk("mr_ready", alloc_ready, 1);
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reorder_status_table.md
# reorder_status_table

Per-packet verdict table between the parallel packet-filter cores and the circular buffer. The forwarder allocates an entry when it hands a packet to the buffer under a reorder tag. The filter cores later post accept/reject verdicts by tag. The circular buffer reads the 2-bit status of its current output tag and releases the entry once the packet is sent or skipped.

## Interface
Parameters:
- TAG_WIDTH, 6, width of reorder tags
- TABLE_SIZE, 50, number of entries; legal tags are 0..TABLE_SIZE-1
- N_CORES, 4, number of filter-core verdict ports
- CNT_WIDTH, 32, width of the statistics counters

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- alloc_valid  in  1  forwarder requests that entry alloc_tag be marked pending
- alloc_tag  in  TAG_WIDTH  tag being allocated
- alloc_ready  out  1  entry alloc_tag is FREE and alloc_tag < TABLE_SIZE (combinational)
- vrd_valid  in  N_CORES  per-core verdict strobe
- vrd_tag  in  N_CORES*TAG_WIDTH  per-core tag; core k occupies bits [k*TAG_WIDTH +: TAG_WIDTH]
- vrd_accept  in  N_CORES  1 = accept, 0 = reject
- rd_tag  in  TAG_WIDTH  tag currently at the buffer output pointer
- packet_status  out  2  status of rd_tag (combinational from registered state)
- release  in  1  one-cycle pulse that frees entry rd_tag
- pending_count  out  TAG_WIDTH+1  number of non-FREE entries
- accept_cnt  out  CNT_WIDTH  verdicts accepted since reset
- reject_cnt  out  CNT_WIDTH  verdicts rejected since reset
- err_sticky  out  1  protocol violation seen since reset

## Operation
- Status encoding: FREE=2'b00, PENDING=2'b10, REJECT=2'b01, ACCEPT=2'b11. The buffer acts only on 11 and 01.
- Per-entry state machine:
  - FREE to PENDING on alloc handshake (alloc_valid && alloc_ready).
  - PENDING to ACCEPT or REJECT on a verdict.
  - ACCEPT or REJECT to FREE on release when rd_tag matches.
  - Any other event is a no-op on the entry.
- Verdicts:
  - All cores are processed in the same cycle.
  - If two or more valid cores carry the same tag, the lowest core index wins and err_sticky is set.
  - accept_cnt/reject_cnt increment by the number of verdicts that take effect in that cycle (0..N_CORES). They wrap modulo 2^CNT_WIDTH.
- Error conditions (entry unchanged, err_sticky set):
  - verdict to a FREE or already-decided entry
  - verdict or release with tag >= TABLE_SIZE
  - release of a PENDING or FREE entry
  - alloc_valid while alloc_ready is low (request is held, not an error)
- pending_count: +1 per alloc handshake, -1 per effective release. Both in the same cycle gives a net 0.
- packet_status for rd_tag >= TABLE_SIZE reads FREE.

## Timing
- Reset: all entries FREE; pending_count=0, accept_cnt=0, reject_cnt=0, err_sticky=0. Consequently alloc_ready=1 for any legal tag and packet_status=00.
- Reset asserted mid-operation discards every entry and counter on the next edge; inputs in that cycle are ignored.
- A verdict posted in cycle N appears on packet_status in cycle N+1 when rd_tag matches.
- Alloc in cycle N shows PENDING in N+1.
- Release in cycle N shows FREE in N+1, and alloc_ready for that tag rises in N+1.
- Same-cycle collisions on one tag:
  - Release and verdict: release acts on the pre-edge state. The verdict sees the pre-edge status, so it is an error if that status is decided; the release wins.
  - Release and alloc: alloc_ready is computed from the pre-edge state and is low, so no handshake occurs.
  - Alloc and verdict: the verdict sees FREE, so it is an error and the entry goes to PENDING.
- Wrap-around: tags are used cyclically by the forwarder. The table imposes no ordering; backpressure comes only from alloc_ready.

## Structure
- Package reorder_pkg holds:
  - status localparams FREE, PENDING, REJECT, ACCEPT
  - a function that resolves N_CORES verdicts to a winner per tag
  - TAG_WIDTH and TABLE_SIZE defaults shared with the circular buffer and forwarder
- Sub-module verdict_popcount: a combinational count of effective accepts/rejects feeding both counters.
- Entry state is an array of 2-bit registers with no RAM inference.

## Test plan
- After reset: alloc tag 5, then core 2 posts accept on 5, then release with rd_tag=5. Expect:
  - packet_status sequence 00, 10, 11, 00
  - accept_cnt=1, pending_count 0, 1, 1, 0
- Cores 0 and 3 post verdicts the same cycle on pending tags 7 (reject) and 9 (accept). Expect:
  - tag 7 status 01, tag 9 status 11
  - accept_cnt=1, reject_cnt=1, err_sticky=0
- Cores 1 and 2 both post on pending tag 4 (1 = accept, 2 = reject). Expect status 11, accept_cnt=1, reject_cnt=0, err_sticky=1.
- Fill tags 0..49 by allocating each. Expect pending_count=50 and alloc_ready=0 for tag 0. Release tag 0 after it is accepted; the next cycle alloc_ready=1, then re-alloc tag 0 (wrap).
- Same-cycle release and alloc on decided tag 12. Expect:
  - alloc_ready=0 that cycle and the entry goes FREE
  - alloc held and completing next cycle, giving PENDING, with pending_count unchanged overall
- Errors:
  - verdict to FREE tag 20: err_sticky=1, status stays 00
  - verdict with tag 55: err_sticky=1, status stays 00
  - assert rst with 3 entries pending: all outputs return to reset values the next cycle
